// File: rtl/mc14500_pkg.sv
// rtl/mc14500_pkg.sv - shared types for the MC14500B fetch/decode path
package mc14500_pkg;

    localparam int OPCODE_WIDTH = 4;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        NOPO = 4'h0,
        LD   = 4'h1,
        LDC  = 4'h2,
        AND  = 4'h3,
        ANDC = 4'h4,
        OR   = 4'h5,
        ORC  = 4'h6,
        XNOR = 4'h7,
        STO  = 4'h8,
        STOC = 4'h9,
        IEN  = 4'hA,
        OEN  = 4'hB,
        JMP  = 4'hC,
        RTN  = 4'hD,
        SKZ  = 4'hE,
        NOPF = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        PC_INC  = 2'b00,
        PC_JMP  = 2'b01,
        PC_RTN  = 2'b10,
        PC_CALL = 2'b11
    } pc_op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_READ    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_PRESENT = 3'd3,
        ST_RELEASE = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - opcode to program-counter operation map
module instr_decode
    import mc14500_pkg::*;
(
    input  opcode_e opcode,
    output pc_op_e  pc_op
);

    always_comb begin
        pc_op = PC_INC;
        case (opcode)
            JMP:     pc_op = PC_JMP;
            RTN:     pc_op = PC_RTN;
            NOPF:    pc_op = PC_CALL;
            default: pc_op = PC_INC;
        endcase
    end

endmodule

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - MC14500B fetch stage with req/ack handshakes
// Optional SKZ skip squashing is enabled by defining SKZ_SQUASH_EN (adds port rr).
module instruction_fetch
    import mc14500_pkg::*;
#(
    parameter int ADDR_WIDTH    = 8,
    parameter int OPERAND_WIDTH = 8,
    parameter int MEM_LATENCY   = 1
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic [ADDR_WIDTH-1:0]                 pc_address,
    output logic                                  mem_rd,
    output logic [ADDR_WIDTH-1:0]                 mem_addr,
    input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] mem_data,
    input  logic                                  req_prev,
    output logic                                  ack_prev,
    output logic                                  req_next,
    input  logic                                  ack_next,
    output logic [OPCODE_WIDTH-1:0]               opcode,
    output logic [OPERAND_WIDTH-1:0]              operand,
    output logic [1:0]                            pc_op,
    output logic [ADDR_WIDTH-1:0]                 jump_target
`ifdef SKZ_SQUASH_EN
    ,
    input  logic                                  rr
`endif
);

    localparam int LAT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

    fetch_state_e               state, state_d;
    logic [LAT_W-1:0]           lat_cnt;
    logic                       start, capture;
    opcode_e                    opcode_q, word_opcode, cap_opcode;
    logic [OPERAND_WIDTH-1:0]   operand_q, word_operand, cap_operand;
    pc_op_e                     pc_op_w;

    assign word_opcode  = opcode_e'(mem_data[OPERAND_WIDTH +: OPCODE_WIDTH]);
    assign word_operand = mem_data[OPERAND_WIDTH-1:0];

    // A held req_prev cannot refetch: RELEASE only exits once req_prev is low.
    always_comb begin
        state_d  = state;
        start    = 1'b0;
        capture  = 1'b0;
        mem_rd   = 1'b0;
        req_next = 1'b0;
        ack_prev = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_prev && !ack_next) begin
                    start   = 1'b1;
                    state_d = ST_READ;
                end
            end
            ST_READ: begin
                mem_rd  = 1'b1;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (lat_cnt == '0) begin
                    capture = 1'b1;
                    state_d = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                req_next = 1'b1;
                ack_prev = 1'b1;
                if (ack_next) state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                ack_prev = 1'b1;
                if (!req_prev && !ack_next) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            lat_cnt   <= '0;
            mem_addr  <= '0;
            opcode_q  <= NOPO;
            operand_q <= '0;
        end else begin
            state <= state_d;
            if (start) mem_addr <= pc_address;
            if (state == ST_READ) begin
                lat_cnt <= LAT_W'(MEM_LATENCY - 1);
            end else if (state == ST_WAIT && lat_cnt != '0) begin
                lat_cnt <= lat_cnt - 1'b1;
            end
            if (capture) begin
                opcode_q  <= cap_opcode;
                operand_q <= cap_operand;
            end
        end
    end

`ifdef SKZ_SQUASH_EN
    // Set only when the SKZ word lands with rr low, so it directly means "squash the next word".
    logic skip_pending;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            skip_pending <= 1'b0;
        end else if (capture) begin
            skip_pending <= !skip_pending && (word_opcode == SKZ) && !rr;
        end
    end

    assign cap_opcode  = skip_pending ? NOPO : word_opcode;
    assign cap_operand = skip_pending ? '0 : word_operand;
`else
    assign cap_opcode  = word_opcode;
    assign cap_operand = word_operand;
`endif

    instr_decode u_decode (
        .opcode (opcode_q),
        .pc_op  (pc_op_w)
    );

    assign opcode  = opcode_q;
    assign operand = operand_q;
    assign pc_op   = pc_op_w;

    generate
        if (OPERAND_WIDTH >= ADDR_WIDTH) begin : g_jt_trunc
            assign jump_target = operand_q[ADDR_WIDTH-1:0];
        end else begin : g_jt_zext
            assign jump_target = {{(ADDR_WIDTH-OPERAND_WIDTH){1'b0}}, operand_q};
        end
    endgenerate

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch at ROM latency 1 and 3
module tb_instruction_fetch;

    typedef struct packed {
        logic [7:0] addr;
        logic [3:0] opc;
        logic [7:0] opr;
        logic [1:0] pco;
        logic [7:0] jt;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic [7:0]  pc_address [2];
    logic        mem_rd     [2];
    logic [7:0]  mem_addr   [2];
    logic [11:0] mem_data   [2];
    logic        req_prev   [2];
    logic        ack_prev   [2];
    logic        req_next   [2];
    logic        ack_next   [2];
    logic [3:0]  opcode     [2];
    logic [7:0]  operand    [2];
    logic [1:0]  pc_op      [2];
    logic [7:0]  jump_target[2];
`ifdef SKZ_SQUASH_EN
    logic        rr         [2];
    logic        squash     [2];
`endif

    logic [11:0] rom [256];
    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          rd_cnt [2] = '{0, 0};
    int          rd_cyc [2] = '{0, 0};
    logic [7:0]  rd_addr[2];
    logic        rn_prev[2] = '{1'b0, 1'b0};
    logic [21:0] shown  [2];
    int          due    [2] = '{-10, -10};
    logic [11:0] due_word[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    instruction_fetch #(.ADDR_WIDTH(8), .OPERAND_WIDTH(8), .MEM_LATENCY(1)) u0 (
        .clk(clk), .reset_n(reset_n), .pc_address(pc_address[0]),
        .mem_rd(mem_rd[0]), .mem_addr(mem_addr[0]), .mem_data(mem_data[0]),
        .req_prev(req_prev[0]), .ack_prev(ack_prev[0]),
        .req_next(req_next[0]), .ack_next(ack_next[0]),
        .opcode(opcode[0]), .operand(operand[0]), .pc_op(pc_op[0]),
        .jump_target(jump_target[0])
`ifdef SKZ_SQUASH_EN
        , .rr(rr[0])
`endif
    );

    instruction_fetch #(.ADDR_WIDTH(8), .OPERAND_WIDTH(8), .MEM_LATENCY(3)) u1 (
        .clk(clk), .reset_n(reset_n), .pc_address(pc_address[1]),
        .mem_rd(mem_rd[1]), .mem_addr(mem_addr[1]), .mem_data(mem_data[1]),
        .req_prev(req_prev[1]), .ack_prev(ack_prev[1]),
        .req_next(req_next[1]), .ack_next(ack_next[1]),
        .opcode(opcode[1]), .operand(operand[1]), .pc_op(pc_op[1]),
        .jump_target(jump_target[1])
`ifdef SKZ_SQUASH_EN
        , .rr(rr[1])
`endif
    );

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [1:0] ref_pc_op(input logic [3:0] opc);
        if (opc == 4'hC) return 2'b01;
        if (opc == 4'hD) return 2'b10;
        if (opc == 4'hF) return 2'b11;
        return 2'b00;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // ROM: the read word is visible only during the cycle MEM_LATENCY after mem_rd.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (mem_rd[i]) begin
                due[i]      = cyc + lat(i);
                due_word[i] = rom[mem_addr[i]];
            end
            mem_data[i] = (cyc == due[i]) ? due_word[i] : 12'($urandom);
        end
    end

    always @(negedge clk) begin
        exp_t e;
        int   qs;
        for (int i = 0; i < 2; i++) begin
            if (mem_rd[i]) begin
                rd_cnt[i]++;
                rd_cyc[i]  = cyc;
                rd_addr[i] = mem_addr[i];
            end
            if (req_next[i] && !rn_prev[i]) begin
                qs = (i == 0) ? q0.size() : q1.size();
                chk("expectation_pending", 64'(qs != 0), 64'(1));
                if (qs != 0) begin
                    if (i == 0) e = q0.pop_front();
                    else        e = q1.pop_front();
                    chk("mem_addr",    64'(rd_addr[i]),     64'(e.addr));
                    chk("opcode",      64'(opcode[i]),      64'(e.opc));
                    chk("operand",     64'(operand[i]),     64'(e.opr));
                    chk("pc_op",       64'(pc_op[i]),       64'(e.pco));
                    chk("jump_target", 64'(jump_target[i]), 64'(e.jt));
                    chk("latency",     64'(cyc - rd_cyc[i]), 64'(lat(i) + 1));
                    chk("ack_prev_with_req_next", 64'(ack_prev[i]), 64'(1));
                end
                shown[i] = {opcode[i], operand[i], pc_op[i], jump_target[i]};
            end else if (req_next[i]) begin
                chk("outputs_frozen", 64'({opcode[i], operand[i], pc_op[i], jump_target[i]}), 64'(shown[i]));
            end
            rn_prev[i] = req_next[i];
        end
    end

    task automatic fetch(input int i, input logic [7:0] addr, input int ack_dly,
                         input logic hold, input logic stall);
        exp_t        e;
        logic [11:0] w;
        int          t;
        int          n0;
        @(negedge clk);
        pc_address[i] = addr;
        w      = rom[addr];
        e.addr = addr;
        e.opc  = w[11:8];
        e.opr  = w[7:0];
`ifdef SKZ_SQUASH_EN
        if (squash[i]) begin
            e.opc     = 4'h0;
            e.opr     = 8'h00;
            squash[i] = 1'b0;
        end else begin
            squash[i] = (w[11:8] == 4'hE) && !rr[i];
        end
`endif
        e.pco = ref_pc_op(e.opc);
        e.jt  = e.opr;
        if (i == 0) q0.push_back(e);
        else        q1.push_back(e);
        n0 = rd_cnt[i];
        req_prev[i] = 1'b1;
        if (stall) begin
            ack_next[i] = 1'b1;
            repeat (4) @(negedge clk);
            chk("stall_no_rd", 64'(rd_cnt[i]), 64'(n0));
            ack_next[i] = 1'b0;
        end
        t = 0;
        while (!req_next[i] && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("req_next_rise", 64'(req_next[i]), 64'(1));
        repeat (ack_dly) @(negedge clk);
        ack_next[i] = 1'b1;
        t = 0;
        while (req_next[i] && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("req_next_drop", 64'(req_next[i]), 64'(0));
        chk("ack_prev_held", 64'(ack_prev[i]), 64'(1));
        if (hold) begin
            ack_next[i] = 1'b0;
            repeat (3) @(negedge clk);
            chk("ack_prev_until_req_drop", 64'(ack_prev[i]), 64'(1));
        end
        chk("one_rd_per_fetch", 64'(rd_cnt[i]), 64'(n0 + 1));
        req_prev[i] = 1'b0;
        ack_next[i] = 1'b0;
        t = 0;
        while (ack_prev[i] && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("ack_prev_drop", 64'(ack_prev[i]), 64'(0));
    endtask

    task automatic mid_reset(input int i);
        int t;
        int n0;
        @(negedge clk);
        n0 = rd_cnt[i];
        pc_address[i] = 8'h05;
        req_prev[i]   = 1'b1;
        t = 0;
        while (!mem_rd[i] && t < 10) begin
            @(negedge clk);
            t++;
        end
        chk("mid_reset_rd", 64'(mem_rd[i]), 64'(1));
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("mid_reset_outputs", 64'({req_next[i], ack_prev[i], mem_rd[i]}), 64'(0));
        req_prev[i] = 1'b0;
`ifdef SKZ_SQUASH_EN
        squash[0] = 1'b0;
        squash[1] = 1'b0;
`endif
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (lat(i) + 4) @(negedge clk);
        chk("mid_reset_no_req_next", 64'(req_next[i]), 64'(0));
        chk("mid_reset_rd_count", 64'(rd_cnt[i]), 64'(n0 + 1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 12'($urandom);
        rom[8'h05] = 12'h13A;
        rom[8'h10] = 12'hC20;
        rom[8'h11] = 12'hD00;
        rom[8'h12] = 12'hF40;
        rom[8'h20] = 12'hE00;
        rom[8'h21] = 12'h13A;
        for (int i = 0; i < 2; i++) begin
            pc_address[i] = 8'h00;
            req_prev[i]   = 1'b1;
            ack_next[i]   = 1'b0;
`ifdef SKZ_SQUASH_EN
            rr[i]     = 1'b0;
            squash[i] = 1'b0;
`endif
        end
        #2 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("reset_outputs", 64'({mem_rd[i], mem_addr[i], ack_prev[i], req_next[i],
                                      opcode[i], operand[i], pc_op[i], jump_target[i]}), 64'(0));
            chk("reset_no_rd", 64'(rd_cnt[i]), 64'(0));
            req_prev[i] = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 2; i++) begin
            fetch(i, 8'h05, 0, 1'b0, 1'b0);
            fetch(i, 8'h10, 5, 1'b0, 1'b0);
            fetch(i, 8'h11, 0, 1'b1, 1'b0);
            fetch(i, 8'h12, 1, 1'b0, 1'b1);
            mid_reset(i);
            fetch(i, 8'h05, 0, 1'b0, 1'b0);
`ifdef SKZ_SQUASH_EN
            rr[i] = 1'b0;
            fetch(i, 8'h20, 0, 1'b0, 1'b0);
            fetch(i, 8'h21, 0, 1'b0, 1'b0);
            rr[i] = 1'b1;
            fetch(i, 8'h20, 0, 1'b0, 1'b0);
            fetch(i, 8'h21, 0, 1'b0, 1'b0);
`endif
            for (int n = 0; n < 25; n++) begin
`ifdef SKZ_SQUASH_EN
                rr[i] = ($urandom_range(0, 1) == 1);
`endif
                fetch(i, 8'($urandom), int'($urandom_range(0, 4)),
                      ($urandom_range(0, 1) == 1), ($urandom_range(0, 3) == 0));
            end
        end

        repeat (5) @(negedge clk);
        chk("scoreboard_drained_0", 64'(q0.size()), 64'(0));
        chk("scoreboard_drained_1", 64'(q1.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
